// File: rtl/cr_huf_comp_sc_coalesce_fifo.sv
// Symbol-count FIFO: a staging register coalesces identical symbol runs, then feeds a FWFT flop array.
// Write-to-read latency 2 cycles (stage + push); wr_rdy_o is credit-based, full pushes are dropped and flagged.
module cr_huf_comp_sc_coalesce_fifo #(
   parameter int  DEPTH     = 256,
   parameter int  SYM_W     = 8,
   parameter int  SEQ_W     = 4,
   parameter int  CNT_W     = 3,
   parameter int  RDY_SLACK = 4,
   parameter int  COALESCE  = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             wr_i,
   input  logic             wr_vld_i,
   input  logic [SYM_W-1:0] wr_sym_i,
   input  logic [SEQ_W-1:0] wr_seq_i,
   input  logic [1:0]       wr_eob_i,
   output logic             wr_rdy_o,
   input  logic             rd_i,
   output logic             rd_vld_o,
   output logic [CNT_W-1:0] rd_cnt_o,
   output logic [SYM_W-1:0] rd_sym_o,
   output logic [SEQ_W-1:0] rd_seq_o,
   output logic [1:0]       rd_eob_o,
   output logic [AW:0]      used_o,
   output logic [AW:0]      free_o,
   output logic [AW:0]      hwm_o,
   output logic             overflow_o,
   output logic             underflow_o
);
   localparam int AW1 = AW + 1;
   localparam int AW2 = AW + 2;

   typedef struct packed {
      logic [CNT_W-1:0] cnt;
      logic [SYM_W-1:0] sym;
      logic [SEQ_W-1:0] seq;
      logic [1:0]       eob;
   } ent_t;

   ent_t           mem [DEPTH];
   ent_t           s_ent;
   ent_t           wr_ent;
   ent_t           head;
   logic           s_vld;
   logic [AW-1:0]  wptr;
   logic [AW-1:0]  rptr;
   logic [AW:0]    used;
   logic [AW:0]    hwm;
   logic           ovf;
   logic           udf;
   logic           merge;
   logic           push;
   logic           pop;
   logic           full;
   logic           push_ok;
   logic [AW2-1:0] free_raw;

   // Marker-only writes carry a zero count so they can never absorb a later symbol.
   assign wr_ent = {(wr_vld_i ? CNT_W'(1) : CNT_W'(0)), wr_sym_i, wr_seq_i, wr_eob_i};

   assign merge = (COALESCE != 0) && s_vld && wr_i && wr_vld_i
                  && (s_ent.cnt != '0) && (s_ent.eob == 2'd0) && (wr_eob_i == 2'd0)
                  && (wr_sym_i == s_ent.sym) && (wr_seq_i == s_ent.seq)
                  && (s_ent.cnt != '1);

   assign push     = s_vld && !merge;
   assign rd_vld_o = (used != '0);
   assign pop      = rd_i && rd_vld_o;
   assign full     = (used == AW1'(DEPTH));
   assign push_ok  = push && (!full || pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_vld <= 1'b0;
         s_ent <= '0;
      end else if (clear) begin
         s_vld <= 1'b0;
         s_ent <= '0;
      end else if (merge) begin
         s_ent.cnt <= s_ent.cnt + 1'b1;
      end else if (wr_i) begin
         s_vld <= 1'b1;
         s_ent <= wr_ent;
      end else begin
         s_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr <= '0;
         rptr <= '0;
         used <= '0;
         hwm  <= '0;
         ovf  <= 1'b0;
         udf  <= 1'b0;
      end else if (clear) begin
         wptr <= '0;
         rptr <= '0;
         used <= '0;
         hwm  <= '0;
         ovf  <= 1'b0;
         udf  <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         if (push_ok && !pop)      used <= used + 1'b1;
         else if (pop && !push_ok) used <= used - 1'b1;
         if (used > hwm) hwm <= used;
         if (push && !push_ok) ovf <= 1'b1;
         if (rd_i && !rd_vld_o) udf <= 1'b1;
      end
   end

   // Array is flushed on clear as well so the head fields read zero afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_ok) begin
         mem[wptr] <= s_ent;
      end
   end

   assign head     = mem[rptr];
   assign rd_cnt_o = head.cnt;
   assign rd_sym_o = head.sym;
   assign rd_seq_o = head.seq;
   assign rd_eob_o = head.eob;

   assign used_o      = used;
   assign hwm_o       = hwm;
   assign overflow_o  = ovf;
   assign underflow_o = udf;

   // A held stage on a full array would make free negative; clamp so wr_rdy_o stays low.
   assign free_raw = AW2'(DEPTH) - AW2'(used) - AW2'(s_vld);
   assign free_o   = free_raw[AW2-1] ? '0 : free_raw[AW:0];
   assign wr_rdy_o = (free_o > AW1'(RDY_SLACK));
endmodule

// File: tb/tb_cr_huf_comp_sc_coalesce_fifo.sv
// Bench: directed coalescing/boundary checks on a 4-deep instance, random traffic on a non-coalescing 8-deep instance.
module tb_cr_huf_comp_sc_coalesce_fifo;
   logic clk;
   logic rst_n;

   // instance A: DEPTH=4, COALESCE=1, RDY_SLACK=1
   logic       a_clear, a_wr, a_vld, a_rd;
   logic [7:0] a_sym;
   logic [3:0] a_seq;
   logic [1:0] a_eob;
   logic       a_rdy, a_rd_vld, a_ovf, a_udf;
   logic [2:0] a_cnt;
   logic [7:0] a_sym_o;
   logic [3:0] a_seq_o;
   logic [1:0] a_eob_o;
   logic [2:0] a_used, a_free, a_hwm;

   // instance B: DEPTH=8, COALESCE=0, RDY_SLACK=2
   logic       b_clear, b_wr, b_vld, b_rd;
   logic [7:0] b_sym;
   logic [3:0] b_seq;
   logic [1:0] b_eob;
   logic       b_rdy, b_rd_vld, b_ovf, b_udf;
   logic [2:0] b_cnt;
   logic [7:0] b_sym_o;
   logic [3:0] b_seq_o;
   logic [1:0] b_eob_o;
   logic [3:0] b_used, b_free, b_hwm;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int cnt;
      int sym;
      int seq;
      int eob;
   } e_t;

   cr_huf_comp_sc_coalesce_fifo #(.DEPTH(4), .SYM_W(8), .SEQ_W(4), .CNT_W(3),
                                  .RDY_SLACK(1), .COALESCE(1)) u_a (
      .clk(clk), .rst_n(rst_n), .clear(a_clear),
      .wr_i(a_wr), .wr_vld_i(a_vld), .wr_sym_i(a_sym), .wr_seq_i(a_seq), .wr_eob_i(a_eob),
      .wr_rdy_o(a_rdy), .rd_i(a_rd), .rd_vld_o(a_rd_vld), .rd_cnt_o(a_cnt),
      .rd_sym_o(a_sym_o), .rd_seq_o(a_seq_o), .rd_eob_o(a_eob_o),
      .used_o(a_used), .free_o(a_free), .hwm_o(a_hwm),
      .overflow_o(a_ovf), .underflow_o(a_udf));

   cr_huf_comp_sc_coalesce_fifo #(.DEPTH(8), .SYM_W(8), .SEQ_W(4), .CNT_W(3),
                                  .RDY_SLACK(2), .COALESCE(0)) u_b (
      .clk(clk), .rst_n(rst_n), .clear(b_clear),
      .wr_i(b_wr), .wr_vld_i(b_vld), .wr_sym_i(b_sym), .wr_seq_i(b_seq), .wr_eob_i(b_eob),
      .wr_rdy_o(b_rdy), .rd_i(b_rd), .rd_vld_o(b_rd_vld), .rd_cnt_o(b_cnt),
      .rd_sym_o(b_sym_o), .rd_seq_o(b_seq_o), .rd_eob_o(b_eob_o),
      .used_o(b_used), .free_o(b_free), .hwm_o(b_hwm),
      .overflow_o(b_ovf), .underflow_o(b_udf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ent(input int cnt, input int sym, input int seq, input int eob);
      logic [2:0] c;
      logic [7:0] s;
      logic [3:0] q;
      logic [1:0] e;
      c = 3'(cnt);
      s = 8'(sym);
      q = 4'(seq);
      e = 2'(eob);
      return {15'd0, c, s, q, e};
   endfunction

   function automatic logic [31:0] a_head();
      return {15'd0, a_cnt, a_sym_o, a_seq_o, a_eob_o};
   endfunction

   function automatic logic [31:0] b_head();
      return {15'd0, b_cnt, b_sym_o, b_seq_o, b_eob_o};
   endfunction

   task automatic a_write(input logic vld, input int sym, input int seq, input int eob);
      a_wr  = 1'b1;
      a_vld = vld;
      a_sym = 8'(sym);
      a_seq = 4'(seq);
      a_eob = 2'(eob);
      tick();
      a_wr  = 1'b0;
   endtask

   task automatic a_pop();
      a_rd = 1'b1;
      tick();
      a_rd = 1'b0;
   endtask

   initial begin
      e_t   q[$];
      e_t   pend;
      e_t   h;
      logic pend_v;
      logic pop_m;
      logic ovf_m;
      logic udf_m;
      int   hwm_m;
      int   free_m;

      rst_n = 1'b0;
      a_clear = 0; a_wr = 0; a_vld = 0; a_rd = 0; a_sym = 0; a_seq = 0; a_eob = 0;
      b_clear = 0; b_wr = 0; b_vld = 0; b_rd = 0; b_sym = 0; b_seq = 0; b_eob = 0;
      repeat (2) tick();
      rst_n = 1'b1;

      // reset values
      chk("rst_rd_vld", 32'(a_rd_vld), 32'd0);
      chk("rst_head", a_head(), 32'd0);
      chk("rst_used", 32'(a_used), 32'd0);
      chk("rst_free", 32'(a_free), 32'd4);
      chk("rst_hwm", 32'(a_hwm), 32'd0);
      chk("rst_ovf", 32'(a_ovf), 32'd0);
      chk("rst_udf", 32'(a_udf), 32'd0);
      chk("rst_rdy", 32'(a_rdy), 32'd1);

      // single write, minimum latency
      a_write(1'b1, 8'h41, 3, 0);
      chk("lat_cycle1_vld", 32'(a_rd_vld), 32'd0);
      tick();
      chk("lat_cycle2_vld", 32'(a_rd_vld), 32'd1);
      chk("lat_head", a_head(), ent(1, 8'h41, 3, 0));
      chk("lat_used", 32'(a_used), 32'd1);
      a_pop();
      chk("lat_pop_used", 32'(a_used), 32'd0);

      // nine identical writes saturate at 7 then start a new run
      repeat (9) a_write(1'b1, 8'h10, 1, 0);
      tick();
      chk("run_used", 32'(a_used), 32'd2);
      chk("run_head0", a_head(), ent(7, 8'h10, 1, 0));
      a_pop();
      chk("run_head1", a_head(), ent(2, 8'h10, 1, 0));
      a_pop();
      chk("run_empty", 32'(a_rd_vld), 32'd0);
      chk("run_hwm", 32'(a_hwm), 32'd2);

      // eob blocks merging; marker entry has zero count
      a_write(1'b1, 8'h10, 1, 0);
      a_write(1'b1, 8'h10, 1, 0);
      a_write(1'b1, 8'h10, 1, 2);
      a_write(1'b0, 8'h55, 1, 1);
      tick();
      chk("eob_used", 32'(a_used), 32'd3);
      chk("eob_head0", a_head(), ent(2, 8'h10, 1, 0));
      a_pop();
      chk("eob_head1", a_head(), ent(1, 8'h10, 1, 2));
      a_pop();
      chk("eob_marker", a_head(), ent(0, 8'h55, 1, 1));
      a_pop();

      // fill with distinct symbols: credit, overflow, full push with pop
      a_write(1'b1, 1, 0, 0);
      a_write(1'b1, 2, 0, 0);
      a_write(1'b1, 3, 0, 0);
      chk("fill_free", 32'(a_free), 32'd1);
      chk("fill_rdy_low", 32'(a_rdy), 32'd0);
      a_write(1'b1, 4, 0, 0);
      a_write(1'b1, 5, 0, 0);
      tick();
      chk("full_used", 32'(a_used), 32'd4);
      chk("full_ovf", 32'(a_ovf), 32'd1);
      chk("full_free", 32'(a_free), 32'd0);
      chk("full_head", a_head(), ent(1, 1, 0, 0));
      a_write(1'b1, 6, 0, 0);
      a_pop();
      chk("fullpop_used", 32'(a_used), 32'd4);
      chk("fullpop_head", a_head(), ent(1, 2, 0, 0));
      a_pop();
      chk("wrap_head3", a_head(), ent(1, 3, 0, 0));
      a_pop();
      chk("wrap_head4", a_head(), ent(1, 4, 0, 0));
      a_pop();
      chk("wrap_head6", a_head(), ent(1, 6, 0, 0));
      a_pop();
      chk("drain_used", 32'(a_used), 32'd0);
      chk("drain_hwm", 32'(a_hwm), 32'd4);

      // underflow is sticky
      a_pop();
      chk("udf_set", 32'(a_udf), 32'd1);
      tick();
      chk("udf_sticky", 32'(a_udf), 32'd1);

      // clear wins over a simultaneous write and read
      a_clear = 1'b1; a_wr = 1'b1; a_vld = 1'b1; a_sym = 8'h77; a_rd = 1'b1;
      tick();
      a_clear = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
      chk("clr_ovf", 32'(a_ovf), 32'd0);
      chk("clr_udf", 32'(a_udf), 32'd0);
      chk("clr_hwm", 32'(a_hwm), 32'd0);
      chk("clr_used", 32'(a_used), 32'd0);
      chk("clr_free", 32'(a_free), 32'd4);
      chk("clr_head", a_head(), 32'd0);
      tick();
      chk("clr_wr_discarded", 32'(a_rd_vld), 32'd0);

      // asynchronous reset mid-run discards array and stage
      a_write(1'b1, 8'h21, 0, 0);
      a_write(1'b1, 8'h22, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_used", 32'(a_used), 32'd0);
      chk("arst_free", 32'(a_free), 32'd4);
      rst_n = 1'b1;
      tick();
      chk("arst_no_stage", 32'(a_rd_vld), 32'd0);
      chk("arst_hwm", 32'(a_hwm), 32'd0);

      // random traffic on the non-coalescing instance against a queue model
      pend_v = 1'b0;
      pend   = '{0, 0, 0, 0};
      ovf_m  = 1'b0;
      udf_m  = 1'b0;
      hwm_m  = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         b_wr  = ($urandom_range(0, 99) < 60);
         b_vld = ($urandom_range(0, 3) != 0);
         b_sym = 8'($urandom);
         b_seq = 4'($urandom);
         b_eob = 2'($urandom_range(0, 3));
         b_rd  = ($urandom_range(0, 99) < 50);

         if (q.size() > hwm_m) hwm_m = q.size();
         pop_m = b_rd && (q.size() > 0);
         if (b_rd && q.size() == 0) udf_m = 1'b1;
         if (pop_m) void'(q.pop_front());
         if (pend_v) begin
            if (q.size() < 8) q.push_back(pend);
            else ovf_m = 1'b1;
         end
         pend_v = b_wr;
         pend   = '{b_vld ? 1 : 0, int'(b_sym), int'(b_seq), int'(b_eob)};

         tick();
         chk("rnd_vld", 32'(b_rd_vld), 32'(q.size() > 0));
         chk("rnd_used", 32'(b_used), 32'(q.size()));
         chk("rnd_hwm", 32'(b_hwm), 32'(hwm_m));
         chk("rnd_ovf", 32'(b_ovf), 32'(ovf_m));
         chk("rnd_udf", 32'(b_udf), 32'(udf_m));
         free_m = 8 - q.size() - (pend_v ? 1 : 0);
         if (free_m < 0) free_m = 0;
         chk("rnd_free", 32'(b_free), 32'(free_m));
         chk("rnd_rdy", 32'(b_rdy), 32'(free_m > 2));
         if (q.size() > 0) begin
            h = q[0];
            chk("rnd_head", b_head(), ent(h.cnt, h.sym, h.seq, h.eob));
         end
      end
      b_wr = 1'b0;
      b_rd = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
